// File: rtl/pipelined_avg_tree.sv
// Pipelined N-input unsigned averager: registered adder tree, then one shift/round/saturate stage.
// All stages advance together under a single valid/ready stall signal.
module pipelined_avg_tree #(
    parameter int DATAWIDTH = 16,
    parameter int NUM_IN    = 8,
    parameter int SAW       = 8,
    localparam int LOG2N    = $clog2(NUM_IN),
    localparam int SUMW     = DATAWIDTH + LOG2N
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [NUM_IN*DATAWIDTH-1:0]   i_in_data,
    input  logic [SAW-1:0]                i_sa,
    input  logic                          i_mode,
    input  logic                          i_round_en,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [DATAWIDTH-1:0]          o_avg,
    output logic [SUMW-1:0]               o_sum
);

    localparam logic [SUMW:0] ONE     = 1;
    localparam logic [SUMW:0] SAT_LIM = {{(SUMW+1-DATAWIDTH){1'b0}}, {DATAWIDTH{1'b1}}};

    logic                  r_out_valid;
    logic [DATAWIDTH-1:0]  r_avg;
    logic [SUMW-1:0]       r_sum;
    logic                  w_advance;
    logic                  w_accept;

    assign w_advance  = ~r_out_valid | i_out_ready;
    assign w_accept   = i_in_valid & w_advance;
    assign o_in_ready = w_advance;

    genvar gi, gk;
    generate
        for (gi = 0; gi <= LOG2N; gi++) begin : g_lvl
            localparam int W = DATAWIDTH + gi;
            localparam int N = NUM_IN >> gi;

            logic [W-1:0]   w_node [N];
            logic           w_vld;
            logic [SAW-1:0] w_sa;
            logic           w_mode;
            logic           w_round;

            if (gi == 0) begin : g_in
                assign w_vld   = w_accept;
                assign w_sa    = i_sa;
                assign w_mode  = i_mode;
                assign w_round = i_round_en;
                for (gk = 0; gk < N; gk++) begin : g_split
                    assign w_node[gk] = i_in_data[gk*DATAWIDTH +: DATAWIDTH];
                end
            end else begin : g_add
                logic           r_vld;
                logic [SAW-1:0] r_sa;
                logic           r_mode;
                logic           r_round;

                // Controls ride alongside the data so each vector keeps its own settings.
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        r_vld   <= 1'b0;
                        r_sa    <= '0;
                        r_mode  <= 1'b0;
                        r_round <= 1'b0;
                    end else if (w_advance) begin
                        r_vld <= g_lvl[gi-1].w_vld;
                        if (g_lvl[gi-1].w_vld) begin
                            r_sa    <= g_lvl[gi-1].w_sa;
                            r_mode  <= g_lvl[gi-1].w_mode;
                            r_round <= g_lvl[gi-1].w_round;
                        end
                    end
                end

                assign w_vld   = r_vld;
                assign w_sa    = r_sa;
                assign w_mode  = r_mode;
                assign w_round = r_round;

                for (gk = 0; gk < N; gk++) begin : g_pair
                    logic [W-1:0] r_node;

                    always_ff @(posedge i_clk) begin
                        if (w_advance && g_lvl[gi-1].w_vld) begin
                            r_node <= {1'b0, g_lvl[gi-1].w_node[2*gk]}
                                    + {1'b0, g_lvl[gi-1].w_node[2*gk+1]};
                        end
                    end

                    assign w_node[gk] = r_node;
                end
            end
        end
    endgenerate

    logic [SUMW-1:0]      w_tree_sum;
    logic [31:0]          w_s;
    logic [SUMW:0]        w_r;
    logic [SUMW:0]        w_q;
    logic [DATAWIDTH-1:0] w_avg;

    assign w_tree_sum = g_lvl[LOG2N].w_node[0];

    // Shift amounts beyond the sum width flush to zero and skip the rounding increment.
    always_comb begin
        w_s = g_lvl[LOG2N].w_mode ? 32'(g_lvl[LOG2N].w_sa) : 32'(LOG2N);
        w_r = {1'b0, w_tree_sum};
        if (g_lvl[LOG2N].w_round && (w_s != 32'd0) && (w_s <= 32'(SUMW))) begin
            w_r = {1'b0, w_tree_sum} + (ONE << (w_s - 32'd1));
        end
        w_q   = (w_s > 32'(SUMW)) ? '0 : (w_r >> w_s);
        w_avg = (w_q > SAT_LIM) ? '1 : w_q[DATAWIDTH-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_avg       <= '0;
            r_sum       <= '0;
        end else if (w_advance) begin
            r_out_valid <= g_lvl[LOG2N].w_vld;
            if (g_lvl[LOG2N].w_vld) begin
                r_avg <= w_avg;
                r_sum <= w_tree_sum;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_avg       = r_avg;
    assign o_sum       = r_sum;

endmodule

// File: tb/tb_pipelined_avg_tree.sv
// Scoreboard bench for pipelined_avg_tree (NUM_IN=8, DATAWIDTH=16): driver pushes arithmetic
// reference results, an independent monitor pops and compares on every output handshake.
module tb_pipelined_avg_tree;

    localparam int DW   = 16;
    localparam int NI   = 8;
    localparam int SUMW = 19;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_in_valid = 1'b0;
    logic               o_in_ready;
    logic [NI*DW-1:0]   i_in_data = '0;
    logic [7:0]         i_sa = '0;
    logic               i_mode = 1'b0;
    logic               i_round_en = 1'b0;
    logic               o_out_valid;
    logic               i_out_ready = 1'b1;
    logic [DW-1:0]      o_avg;
    logic [SUMW-1:0]    o_sum;

    pipelined_avg_tree #(.DATAWIDTH(DW), .NUM_IN(NI), .SAW(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_sa(i_sa), .i_mode(i_mode), .i_round_en(i_round_en),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_avg(o_avg), .o_sum(o_sum)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0]   avg;
        logic [SUMW-1:0] sum;
        int              cyc;
        bit              lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;
    int   n_out    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference: plain integer mean/shift/round/saturate.
    function automatic void model(input logic [NI*DW-1:0] d, input int sa, input bit md,
                                  input bit rnd, output logic [DW-1:0] a, output logic [SUMW-1:0] s);
        longint tot;
        longint r;
        longint q;
        int     sh;
        tot = 0;
        for (int k = 0; k < NI; k++) tot += longint'(d[k*DW +: DW]);
        sh = md ? sa : 3;
        if (sh > SUMW) q = 0;
        else begin
            r = tot;
            if (rnd && sh > 0) r += (longint'(1) << (sh - 1));
            q = r >> sh;
        end
        a = (q > 65535) ? 16'hFFFF : q[DW-1:0];
        s = tot[SUMW-1:0];
    endfunction

    // Out_ready pattern generator: 0 always ready, 1 the 1,0,0 cycle, 2 random.
    int pat_idx = 0;
    initial forever begin
        @(posedge i_clk); #1;
        case (rdy_mode)
            0: i_out_ready = 1'b1;
            1: begin i_out_ready = (pat_idx % 3 == 0); pat_idx++; end
            default: i_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: in_ready law, output hold under stall, and scoreboard comparisons.
    bit              prev_stall = 0;
    logic [DW-1:0]   prev_avg;
    logic [SUMW-1:0] prev_sum;
    always @(negedge i_clk) begin
        if (i_rst) prev_stall = 0;
        else begin
            checks++;
            if (o_in_ready !== !(o_out_valid && !i_out_ready)) begin
                failures++;
                $display("FAIL in_ready: got %b want %b", o_in_ready, !(o_out_valid && !i_out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (o_out_valid !== 1'b1 || o_avg !== prev_avg || o_sum !== prev_sum) begin
                    failures++;
                    $display("FAIL hold: got v=%b avg=%h sum=%h want v=1 avg=%h sum=%h",
                             o_out_valid, o_avg, o_sum, prev_avg, prev_sum);
                end
            end
            if (o_out_valid && i_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: got avg=%h sum=%h want no output", o_avg, o_sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_out++;
                    $display("out #%0d avg=%h sum=%h exp avg=%h sum=%h", n_out, o_avg, o_sum, e.avg, e.sum);
                    if (o_avg !== e.avg || o_sum !== e.sum) begin
                        failures++;
                        $display("FAIL result: got avg=%h sum=%h want avg=%h sum=%h", o_avg, o_sum, e.avg, e.sum);
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.cyc != 4) begin
                            failures++;
                            $display("FAIL latency: got %0d want 4", cyc - e.cyc);
                        end
                    end
                end
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_avg   = o_avg;
            prev_sum   = o_sum;
        end
    end

    // Presents one vector (entered at posedge+1) and holds it until accepted.
    task automatic send(input logic [NI*DW-1:0] d, input int sa, input bit md, input bit rnd);
        int   waited;
        bit   done;
        exp_t e;
        waited = 0;
        done   = 0;
        i_in_data = d; i_sa = 8'(sa); i_mode = md; i_round_en = rnd; i_in_valid = 1'b1;
        while (!done) begin
            @(negedge i_clk);
            if (o_in_ready) begin
                model(d, sa, md, rnd, e.avg, e.sum);
                e.cyc = cyc;
                e.lat = (rdy_mode == 0);
                exp_q.push_back(e);
                done = 1;
            end else if (++waited > 200) begin
                checks++; failures++;
                $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
                done = 1;
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        i_in_valid = 1'b0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge i_clk); #1; waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        idle(3);
    endtask

    function automatic logic [NI*DW-1:0] fill(input int base, input int step);
        logic [NI*DW-1:0] v;
        for (int k = 0; k < NI; k++) v[k*DW +: DW] = 16'(base + k*step);
        return v;
    endfunction

    function automatic logic [NI*DW-1:0] rnd_vec();
        logic [NI*DW-1:0] v;
        for (int k = 0; k < NI; k++) v[k*DW +: DW] = 16'($urandom);
        return v;
    endfunction

    logic [NI*DW-1:0] ones_v;

    initial begin
        ones_v = fill(16'hFFFF, 0);
        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_out_valid !== 1'b0 || o_avg !== '0 || o_sum !== '0) begin
            failures++;
            $display("FAIL reset_state: got v=%b avg=%h sum=%h want 0 0 0", o_out_valid, o_avg, o_sum);
        end
        checks++;
        if (o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", o_in_ready);
        end
        i_rst = 1'b0;
        idle(2);

        // Mean, rounding, programmable shift, saturation boundaries
        send(fill(1, 1), 0, 0, 0);
        send(fill(1, 1), 0, 0, 1);
        send(ones_v, 0, 0, 0);
        send(ones_v, 0, 0, 1);
        send(ones_v, 0, 1, 0);
        send(ones_v, 25, 1, 0);
        send(ones_v, 1, 1, 1);
        send(ones_v, 19, 1, 1);
        send(ones_v, 20, 1, 1);
        send(ones_v, 255, 1, 1);
        send(fill(3, 7), 2, 1, 1);
        drain();

        // Per-vector controls alternating on back-to-back vectors
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(rnd_vec(), 0, 0, 0);
            else            send(rnd_vec(), i, 1, 1);
        end
        drain();

        // Back-pressure with out_ready 1,0,0,...
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) send(fill(100 * i + 5, i + 1), i, i % 2, i % 3 == 0);
        drain();

        // Randomised traffic with random gaps and random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(rnd_vec(), $urandom_range(0, 24), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();
        rdy_mode = 0;
        idle(2);

        // Reset mid-stream: one output presented, three vectors behind it
        for (int i = 0; i < 4; i++) send(fill(10 + i, 3), 0, 0, 0);
        i_in_valid = 1'b0;
        #2;
        checks++;
        if (o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: got %b want 1", o_out_valid);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_out_valid !== 1'b0 || o_avg !== '0 || o_sum !== '0) begin
            failures++;
            $display("FAIL midreset: got v=%b avg=%h sum=%h want 0 0 0", o_out_valid, o_avg, o_sum);
        end
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle(10);
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stale_after_reset: got %b want 0", o_out_valid);
        end

        // Pipeline still works after reset
        send(fill(1, 1), 0, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
